// File: rtl/timekeeper_bcd_pkg.sv
// rtl/timekeeper_bcd_pkg.sv - shared encodings, widths and 12-hour mapping for the BCD timekeeper
package timekeeper_bcd_pkg;

    localparam int BCD_W            = 4;
    localparam int TICK_DIV_DEFAULT = 100000000;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } tk_state_e;

    // Returns {pm, H1, H0} for a 12-hour display of the 24-hour BCD hour h1:h0.
    function automatic logic [2*BCD_W:0] hour_to_12h(input logic [BCD_W-1:0] h1,
                                                     input logic [BCD_W-1:0] h0);
        logic [4:0] hb;
        logic [4:0] h12;
        logic       is_pm;
        hb    = 5'(h1) * 5'd10 + 5'(h0);
        is_pm = (hb >= 5'd12);
        if (hb == 5'd0) begin
            h12 = 5'd12;
        end else if (hb > 5'd12) begin
            h12 = hb - 5'd12;
        end else begin
            h12 = hb;
        end
        if (h12 >= 5'd10) begin
            return {is_pm, 4'd1, 4'(h12 - 5'd10)};
        end
        return {is_pm, 4'd0, 4'(h12)};
    endfunction

endpackage

// File: rtl/timekeeper_bcd_counter.sv
// rtl/timekeeper_bcd_counter.sv - two-digit BCD modulo counter used for hours, minutes and seconds
module bcd_mod_counter
    import timekeeper_bcd_pkg::*;
#(
    parameter int TENS_MAX  = 5,
    parameter int UNITS_MAX = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             set_en,
    input  logic             clr,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units,
    output logic             carry_out
);

    localparam logic [BCD_W-1:0] TENS_LIM  = BCD_W'(TENS_MAX);
    localparam logic [BCD_W-1:0] UNITS_LIM = BCD_W'(UNITS_MAX);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] units_q, units_d;
    logic             at_max;

    assign at_max = (tens_q == TENS_LIM) && (units_q == UNITS_LIM);
    // set_en steps the field like inc but never carries into the next field
    assign carry_out = inc && at_max;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc || set_en) begin
            if (at_max) begin
                tens_d  = '0;
                units_d = '0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = '0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/timekeeper_bcd.sv
// rtl/timekeeper_bcd.sv - BCD time-of-day keeper with set FSM and 12/24-hour display
module timekeeper_bcd
    import timekeeper_bcd_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter bit MODE12_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_fmt,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic [1:0]  state,
    output logic        tick,
    output logic        blink
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_HALF = PW'(TICK_DIV / 2);

    tk_state_e        state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             fmt12_q, fmt12_d;

    logic             counting, sec_tick, exit_set, inc_ok;
    logic             sec_carry, min_carry, hr_carry_unused;
    logic [BCD_W-1:0] sec_t, sec_u, min_t, min_u, hr_t, hr_u;
    logic [2*BCD_W:0] hr12;

    always_comb begin
        counting = (state_q == ST_RUN) && en;
        sec_tick = counting && (presc_q == PRESC_LAST);
        exit_set = (state_q == ST_SET_MIN) && btn_mode;
        inc_ok   = btn_inc && !btn_mode;

        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                default:    state_d = ST_RUN;
            endcase
        end

        presc_d = presc_q;
        if (exit_set) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = sec_tick ? '0 : presc_q + 1'b1;
        end

        tick_d  = sec_tick;
        fmt12_d = fmt12_q ^ btn_fmt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            tick_q  <= 1'b0;
            fmt12_q <= MODE12_DEFAULT;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            fmt12_q <= fmt12_d;
        end
    end

    bcd_mod_counter #(.TENS_MAX(5), .UNITS_MAX(9)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_tick),
        .set_en    (1'b0),
        .clr       (exit_set),
        .tens      (sec_t),
        .units     (sec_u),
        .carry_out (sec_carry)
    );

    bcd_mod_counter #(.TENS_MAX(5), .UNITS_MAX(9)) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_carry),
        .set_en    ((state_q == ST_SET_MIN) && inc_ok),
        .clr       (1'b0),
        .tens      (min_t),
        .units     (min_u),
        .carry_out (min_carry)
    );

    // Midnight roll-over is handled inside the hour counter; nothing consumes its carry.
    bcd_mod_counter #(.TENS_MAX(2), .UNITS_MAX(3)) u_hr (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_carry),
        .set_en    ((state_q == ST_SET_HR) && inc_ok),
        .clr       (1'b0),
        .tens      (hr_t),
        .units     (hr_u),
        .carry_out (hr_carry_unused)
    );

    always_comb begin
        hr12 = hour_to_12h(hr_t, hr_u);
        if (fmt12_q) begin
            time_bcd = {hr12[2*BCD_W-1:0], min_t, min_u, sec_t, sec_u};
            pm       = hr12[2*BCD_W];
        end else begin
            time_bcd = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
            pm       = 1'b0;
        end
    end

    assign state = state_q;
    assign tick  = tick_q;
    assign blink = (presc_q >= PRESC_HALF);

endmodule

// File: doc/timekeeper_bcd.md
TIMEKEEPER_BCD -- requirements
Module: timekeeper_bcd

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per 1 s tick (minimum 2).
REQ-002 The block SHALL have parameter MODE12_DEFAULT, default 0, meaning the 12-hour display flag value loaded at reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable while in RUN.
REQ-006 The block SHALL have port btn_mode, input, 1 bit: single-cycle pulse, already debounced, that advances the set FSM.
REQ-007 The block SHALL have port btn_inc, input, 1 bit: single-cycle pulse that increments the field being set.
REQ-008 The block SHALL have port btn_fmt, input, 1 bit: single-cycle pulse that toggles the 12/24-hour display flag.
REQ-009 The block SHALL have port time_bcd, output, 24 bits: {H1,H0,M1,M0,S1,S0}, 4-bit BCD digits, display-formatted.
REQ-010 The block SHALL have port pm, output, 1 bit: PM indicator; always 0 in 24-hour display.
REQ-011 The block SHALL have port state, output, 2 bits: FSM state (RUN=0, SET_HR=1, SET_MIN=2).
REQ-012 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each counted second.
REQ-013 The block SHALL have port blink, output, 1 bit: 1 Hz, 50 % duty signal for flashing the field being set.

Function
REQ-014 Time SHALL be held internally as BCD 24-hour digits: hours 00-23, minutes 00-59, seconds 00-59.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only when state=RUN and en=1; otherwise it holds its value.
REQ-016 When the prescaler is at TICK_DIV-1 and it is counting, the next edge SHALL wrap it to 0, advance seconds by one and assert tick for exactly that cycle.
REQ-017 Carries SHALL ripple in the same cycle: S0 9->0 increments S1; S1:S0 59->00 increments minutes; M59->00 increments hours; 23:59:59 -> 00:00:00.
REQ-018 The hour wrap SHALL be decoded as H1=2 and H0=3; for H1 of 0 or 1, H0 SHALL wrap at 9.
REQ-019 In RUN, btn_mode SHALL move the FSM to SET_HR; in SET_HR it moves to SET_MIN; in SET_MIN it moves to RUN.
REQ-020 On the SET_MIN->RUN transition, seconds and the prescaler SHALL clear to 0.
REQ-021 In SET_HR, btn_inc SHALL increment the hours with wrap 23->00 and no carry; in SET_MIN, it increments the minutes with wrap 59->00 and no carry; in RUN, btn_inc is ignored.
REQ-022 If btn_mode and btn_inc are asserted in the same cycle, btn_mode SHALL act and btn_inc SHALL be ignored.
REQ-023 btn_fmt SHALL toggle the display flag in any state and SHALL NOT alter the stored time.
REQ-024 The 12-hour display SHALL map internal 00 to 12 with pm=0, 01-11 unchanged with pm=0, 12 to 12 with pm=1, and 13-23 to 01-11 with pm=1.
REQ-025 time_bcd and pm SHALL be combinational from the registered state, reflecting each update in the same cycle with zero added latency.
REQ-026 blink SHALL be 1 while the prescaler is >= TICK_DIV/2, and SHALL freeze while the prescaler holds.

Reset
REQ-027 On rst=1 at a clock edge, time SHALL be 00:00:00, the prescaler 0, state=RUN, tick=0 and the display flag MODE12_DEFAULT.
REQ-028 rst SHALL override all buttons and en in the same cycle, including mid-set, which abandons the edit.
REQ-029 Following from REQ-024 and REQ-027, time_bcd after reset SHALL read 000000 in 24-hour display, or 120000 with pm=0 in 12-hour display.

Structure
REQ-030 A shared package/header SHALL hold the FSM state encodings, the BCD digit width (4) and the default TICK_DIV.
REQ-031 A single sub-module bcd_mod_counter SHALL implement the two-digit BCD counter, with parameters for the tens and units wrap limits, plus inc, carry-out, clear and set-enable.
REQ-032 Minutes and seconds SHALL each use one bcd_mod_counter instance; hours SHALL use an instance with the 23 wrap.
REQ-033 The prescaler width SHALL be $clog2(TICK_DIV).

Verification
REQ-034 With TICK_DIV=4, en=1, after reset: 4 clk -> tick pulses once and time_bcd=000001; 240 clk -> 000100.
REQ-035 Preload 23:59:59 via SET plus ticks, then one tick -> 000000 and pm=0 with every digit carrying in that single cycle.
REQ-036 Press btn_mode, btn_inc x25, btn_mode, btn_inc x61, btn_mode -> 010100 is set; then time 01:01:00 and state=RUN with seconds cleared.
REQ-037 At internal 13:05:xx, btn_fmt -> H1H0=01, pm=1; at internal 00:xx, btn_fmt -> 12, pm=0; press btn_fmt again -> 13 / 00 restored.
REQ-038 en=0 for 20 cycles -> time, prescaler and blink frozen, tick=0; simultaneous btn_mode+btn_inc in RUN -> SET_HR with hours unchanged.
REQ-039 Assert rst while in SET_MIN at 17:42 -> next cycle state=RUN and time 000000.
